exec_lsu: RTL and testbench

Parametrised load/store unit for the execute stage. It replaces single-cycle combinational load handling with a registered memory-access FSM. It covers all RISC-V load and store widths with byte-lane steering, sign/zero extension, misalignment detection, access timeout and pipeline flush. It sits between exec (request side) and the data-memory/bus port, and drives the pipeline hold flag while an access is outstanding.

---
 rtl/exec_lsu.sv | 195 +++++++++++++++++++
 tb/tb_exec_lsu.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_lsu.sv
// Execute-stage load/store unit: registered memory-access FSM with byte-lane steering,
// sign/zero extension, misalignment detection, access timeout and pipeline flush.
module exec_lsu #(
  parameter int XLEN           = 32,
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                lsu_req_in,
  input  logic                lsu_is_store_in,
  input  logic [2:0]          lsu_func3_in,
  input  logic [XLEN-1:0]     lsu_base_in,
  input  logic [XLEN-1:0]     lsu_offset_in,
  input  logic [XLEN-1:0]     lsu_store_data_in,
  input  logic [4:0]          lsu_rd_addr_in,
  input  logic                lsu_flush_in,
  output logic                lsu_hold_flag_out,
  output logic                lsu_wen_out,
  output logic [4:0]          lsu_write_addr_out,
  output logic [XLEN-1:0]     lsu_write_data_out,
  output logic                lsu_misalign_out,
  output logic                lsu_timeout_out,
  output logic                lsu_mem_req_out,
  output logic                lsu_mem_we_out,
  output logic [ADDR_W-1:0]   lsu_mem_addr_out,
  output logic [XLEN-1:0]     lsu_mem_wdata_out,
  output logic [XLEN/8-1:0]   lsu_mem_byte_en_out,
  input  logic                lsu_mem_valid_in,
  input  logic [XLEN-1:0]     lsu_mem_rdata_in
);

  localparam int BE_W   = XLEN / 8;
  localparam int LANE_W = $clog2(BE_W);
  localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_t;

  state_t state, state_next;

  logic [XLEN-1:0]   ea_full;
  logic [ADDR_W-1:0] ea;
  logic [LANE_W-1:0] req_lane;
  logic              req_legal;
  logic              req_aligned;
  logic              accept;
  logic              timeout_hit;
  logic [XLEN-1:0]   load_ext;
  logic [XLEN-1:0]   rdata_shifted;

  logic [ADDR_W-1:0] addr_q;
  logic [LANE_W-1:0] lane_q;
  logic [2:0]        func3_q;
  logic [4:0]        rd_q;
  logic              store_q;
  logic [XLEN-1:0]   wdata_q;
  logic [BE_W-1:0]   byte_en_q;
  logic [XLEN-1:0]   load_data_q;
  logic              misalign_q;
  logic [CNT_W-1:0]  cnt;

  function automatic logic [BE_W-1:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    size_mask = BE_W'(8'h01);
      2'd1:    size_mask = BE_W'(8'h03);
      2'd2:    size_mask = BE_W'(8'h0F);
      default: size_mask = BE_W'(8'hFF);
    endcase
  endfunction

  // Replicate the low size bytes of rs2 so every lane carries the store data.
  function automatic logic [XLEN-1:0] steer(input logic [1:0] sz, input logic [XLEN-1:0] d);
    case (sz)
      2'd0:    steer = {BE_W{d[7:0]}};
      2'd1:    steer = {(XLEN/16){d[15:0]}};
      2'd2:    steer = {(XLEN/32){d[31:0]}};
      default: steer = d;
    endcase
  endfunction

  assign ea_full  = lsu_base_in + lsu_offset_in;
  assign ea       = ADDR_W'(ea_full);
  assign req_lane = ea_full[LANE_W-1:0];

  always_comb begin
    req_legal = 1'b0;
    case ({lsu_is_store_in, lsu_func3_in})
      4'b0_000, 4'b0_001, 4'b0_010, 4'b0_100, 4'b0_101: req_legal = 1'b1;
      4'b1_000, 4'b1_001, 4'b1_010:                     req_legal = 1'b1;
      4'b0_011, 4'b0_110, 4'b1_011:                     req_legal = (XLEN == 64);
      default:                                          req_legal = 1'b0;
    endcase
  end

  always_comb begin
    req_aligned = 1'b1;
    case (lsu_func3_in[1:0])
      2'd0:    req_aligned = 1'b1;
      2'd1:    req_aligned = ~ea_full[0];
      2'd2:    req_aligned = (ea_full[1:0] == 2'b00);
      default: req_aligned = (ea_full[2:0] == 3'b000);
    endcase
  end

  assign accept      = (state == IDLE) && lsu_req_in && req_legal;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt >= CNT_LAST);

  // Load data is lane-aligned to bit 0, then extended according to the registered funct3.
  assign rdata_shifted = lsu_mem_rdata_in >> {lane_q, 3'b000};

  always_comb begin
    load_ext = rdata_shifted;
    case (func3_q)
      3'b000:  load_ext = XLEN'($signed(rdata_shifted[7:0]));
      3'b001:  load_ext = XLEN'($signed(rdata_shifted[15:0]));
      3'b010:  load_ext = XLEN'($signed(rdata_shifted[31:0]));
      3'b100:  load_ext = XLEN'(rdata_shifted[7:0]);
      3'b101:  load_ext = XLEN'(rdata_shifted[15:0]);
      3'b110:  load_ext = XLEN'(rdata_shifted[31:0]);
      default: load_ext = rdata_shifted;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) state_next = req_aligned ? ACCESS : ERR;
      end
      ACCESS: begin
        if (lsu_flush_in)          state_next = IDLE;
        else if (lsu_mem_valid_in) state_next = RESP;
        else if (timeout_hit)      state_next = ERR;
      end
      RESP:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      lane_q      <= '0;
      func3_q     <= '0;
      rd_q        <= '0;
      store_q     <= 1'b0;
      wdata_q     <= '0;
      byte_en_q   <= '0;
      load_data_q <= '0;
      misalign_q  <= 1'b0;
      cnt         <= '0;
    end else begin
      if (accept) begin
        addr_q     <= {ea[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
        lane_q     <= req_lane;
        func3_q    <= lsu_func3_in;
        rd_q       <= lsu_rd_addr_in;
        store_q    <= lsu_is_store_in;
        wdata_q    <= steer(lsu_func3_in[1:0], lsu_store_data_in);
        byte_en_q  <= size_mask(lsu_func3_in[1:0]) << req_lane;
        misalign_q <= ~req_aligned;
        cnt        <= '0;
      end else if (state == ACCESS) begin
        if (cnt != {CNT_W{1'b1}}) cnt <= cnt + 1'b1;
        if (lsu_mem_valid_in && !lsu_flush_in) load_data_q <= load_ext;
      end
    end
  end

  // Bus outputs are gated by state so an asynchronous reset drops them immediately.
  always_comb begin
    lsu_hold_flag_out   = (accept && req_aligned) || (state == ACCESS);
    lsu_mem_req_out     = (state == ACCESS);
    lsu_mem_we_out      = (state == ACCESS) && store_q;
    lsu_mem_addr_out    = (state == ACCESS) ? addr_q : '0;
    lsu_mem_wdata_out   = ((state == ACCESS) && store_q) ? wdata_q : '0;
    lsu_mem_byte_en_out = (state == ACCESS) ? byte_en_q : '0;
    lsu_wen_out         = (state == RESP) && !store_q && (rd_q != 5'd0);
    lsu_write_addr_out  = lsu_wen_out ? rd_q : 5'd0;
    lsu_write_data_out  = lsu_wen_out ? load_data_q : '0;
    lsu_misalign_out    = (state == ERR) && misalign_q;
    lsu_timeout_out     = (state == ERR) && !misalign_q;
  end

endmodule

// File: tb/tb_exec_lsu.sv
// Directed bench for exec_lsu (XLEN=32, TIMEOUT_CYCLES=4): loads, stores, misalignment,
// illegal funct3, timeout, flush and asynchronous reset.
module tb_exec_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lsu_req_in;
  logic        lsu_is_store_in;
  logic [2:0]  lsu_func3_in;
  logic [31:0] lsu_base_in;
  logic [31:0] lsu_offset_in;
  logic [31:0] lsu_store_data_in;
  logic [4:0]  lsu_rd_addr_in;
  logic        lsu_flush_in;
  logic        lsu_hold_flag_out;
  logic        lsu_wen_out;
  logic [4:0]  lsu_write_addr_out;
  logic [31:0] lsu_write_data_out;
  logic        lsu_misalign_out;
  logic        lsu_timeout_out;
  logic        lsu_mem_req_out;
  logic        lsu_mem_we_out;
  logic [31:0] lsu_mem_addr_out;
  logic [31:0] lsu_mem_wdata_out;
  logic [3:0]  lsu_mem_byte_en_out;
  logic        lsu_mem_valid_in;
  logic [31:0] lsu_mem_rdata_in;

  int checks   = 0;
  int failures = 0;

  exec_lsu #(.XLEN(32), .ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .lsu_req_in          (lsu_req_in),
    .lsu_is_store_in     (lsu_is_store_in),
    .lsu_func3_in        (lsu_func3_in),
    .lsu_base_in         (lsu_base_in),
    .lsu_offset_in       (lsu_offset_in),
    .lsu_store_data_in   (lsu_store_data_in),
    .lsu_rd_addr_in      (lsu_rd_addr_in),
    .lsu_flush_in        (lsu_flush_in),
    .lsu_hold_flag_out   (lsu_hold_flag_out),
    .lsu_wen_out         (lsu_wen_out),
    .lsu_write_addr_out  (lsu_write_addr_out),
    .lsu_write_data_out  (lsu_write_data_out),
    .lsu_misalign_out    (lsu_misalign_out),
    .lsu_timeout_out     (lsu_timeout_out),
    .lsu_mem_req_out     (lsu_mem_req_out),
    .lsu_mem_we_out      (lsu_mem_we_out),
    .lsu_mem_addr_out    (lsu_mem_addr_out),
    .lsu_mem_wdata_out   (lsu_mem_wdata_out),
    .lsu_mem_byte_en_out (lsu_mem_byte_en_out),
    .lsu_mem_valid_in    (lsu_mem_valid_in),
    .lsu_mem_rdata_in    (lsu_mem_rdata_in)
  );

  always #5 clk = ~clk;

  task automatic drive_idle();
    lsu_req_in        = 1'b0;
    lsu_is_store_in   = 1'b0;
    lsu_func3_in      = 3'b000;
    lsu_base_in       = 32'h0;
    lsu_offset_in     = 32'h0;
    lsu_store_data_in = 32'h0;
    lsu_rd_addr_in    = 5'd0;
    lsu_flush_in      = 1'b0;
    lsu_mem_valid_in  = 1'b0;
    lsu_mem_rdata_in  = 32'h0;
  endtask

  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] base,
                       input logic [31:0] off, input logic [31:0] sd, input logic [4:0] rd);
    lsu_req_in        = 1'b1;
    lsu_is_store_in   = st;
    lsu_func3_in      = f3;
    lsu_base_in       = base;
    lsu_offset_in     = off;
    lsu_store_data_in = sd;
    lsu_rd_addr_in    = rd;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_idle();
    @(negedge clk); #1;
    checks++;
    if ({lsu_hold_flag_out, lsu_wen_out, lsu_misalign_out, lsu_timeout_out, lsu_mem_req_out, lsu_mem_we_out} !== 6'b0) begin
      failures++;
      $display("[TB] FAIL reset_flags: got %b expected 000000",
               {lsu_hold_flag_out, lsu_wen_out, lsu_misalign_out, lsu_timeout_out, lsu_mem_req_out, lsu_mem_we_out});
    end
    checks++;
    if ({lsu_mem_addr_out, lsu_mem_wdata_out, lsu_write_data_out} !== 96'h0) begin
      failures++;
      $display("[TB] FAIL reset_buses: addr %h wdata %h wrdata %h expected 0", lsu_mem_addr_out, lsu_mem_wdata_out, lsu_write_data_out);
    end
    checks++;
    if ({lsu_mem_byte_en_out, lsu_write_addr_out} !== 9'h0) begin
      failures++;
      $display("[TB] FAIL reset_be_rd: got %h expected 0", {lsu_mem_byte_en_out, lsu_write_addr_out});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_lb();
    @(negedge clk); issue(1'b0, 3'b000, 32'h100, 32'h3, 32'h0, 5'd5); #1;
    checks++;
    if (lsu_hold_flag_out !== 1'b1 || lsu_mem_req_out !== 1'b0) begin
      failures++;
      $display("[TB] FAIL lb_c0: hold %b req %b expected 1 0", lsu_hold_flag_out, lsu_mem_req_out);
    end
    @(negedge clk); lsu_req_in = 1'b0; lsu_mem_valid_in = 1'b1; lsu_mem_rdata_in = 32'h80FF1234; #1;
    checks++;
    if (lsu_mem_req_out !== 1'b1 || lsu_mem_we_out !== 1'b0 || lsu_hold_flag_out !== 1'b1 || lsu_wen_out !== 1'b0) begin
      failures++;
      $display("[TB] FAIL lb_c1_ctrl: req %b we %b hold %b wen %b expected 1 0 1 0",
               lsu_mem_req_out, lsu_mem_we_out, lsu_hold_flag_out, lsu_wen_out);
    end
    checks++;
    if (lsu_mem_addr_out !== 32'h100 || lsu_mem_byte_en_out !== 4'b1000) begin
      failures++;
      $display("[TB] FAIL lb_c1_addr: addr %h be %b expected 00000100 1000", lsu_mem_addr_out, lsu_mem_byte_en_out);
    end
    @(negedge clk); lsu_mem_valid_in = 1'b0; lsu_mem_rdata_in = 32'h0; #1;
    checks++;
    if (lsu_wen_out !== 1'b1 || lsu_write_data_out !== 32'hFFFFFF80 || lsu_write_addr_out !== 5'd5) begin
      failures++;
      $display("[TB] FAIL lb_wb: wen %b data %h rd %0d expected 1 ffffff80 5", lsu_wen_out, lsu_write_data_out, lsu_write_addr_out);
    end
    checks++;
    if (lsu_hold_flag_out !== 1'b0 || lsu_mem_req_out !== 1'b0) begin
      failures++;
      $display("[TB] FAIL lb_resp_hold: hold %b req %b expected 0 0", lsu_hold_flag_out, lsu_mem_req_out);
    end
    @(negedge clk); #1;
    checks++;
    if (lsu_wen_out !== 1'b0) begin
      failures++;
      $display("[TB] FAIL lb_wen_pulse: wen %b expected 0", lsu_wen_out);
    end
  endtask

  task automatic test_lhu_wait();
    @(negedge clk); issue(1'b0, 3'b101, 32'h100, 32'h2, 32'h0, 5'd7);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk); lsu_req_in = 1'b0; #1;
      checks++;
      if (lsu_hold_flag_out !== 1'b1 || lsu_mem_req_out !== 1'b1 || lsu_mem_byte_en_out !== 4'b1100) begin
        failures++;
        $display("[TB] FAIL lhu_wait%0d: hold %b req %b be %b expected 1 1 1100",
                 i, lsu_hold_flag_out, lsu_mem_req_out, lsu_mem_byte_en_out);
      end
    end
    @(negedge clk); lsu_mem_valid_in = 1'b1; lsu_mem_rdata_in = 32'h80010000;
    @(negedge clk); lsu_mem_valid_in = 1'b0; #1;
    checks++;
    if (lsu_wen_out !== 1'b1 || lsu_write_data_out !== 32'h00008001 || lsu_write_addr_out !== 5'd7) begin
      failures++;
      $display("[TB] FAIL lhu_wb: wen %b data %h rd %0d expected 1 00008001 7", lsu_wen_out, lsu_write_data_out, lsu_write_addr_out);
    end
  endtask

  task automatic test_store();
    @(negedge clk); issue(1'b1, 3'b000, 32'h100, 32'h1, 32'h123456AB, 5'd9);
    @(negedge clk); lsu_req_in = 1'b0; lsu_mem_valid_in = 1'b1; #1;
    checks++;
    if (lsu_mem_we_out !== 1'b1 || lsu_mem_byte_en_out !== 4'b0010 || lsu_mem_wdata_out !== 32'hABABABAB || lsu_mem_addr_out !== 32'h100) begin
      failures++;
      $display("[TB] FAIL sb_bus: we %b be %b wdata %h addr %h expected 1 0010 abababab 00000100",
               lsu_mem_we_out, lsu_mem_byte_en_out, lsu_mem_wdata_out, lsu_mem_addr_out);
    end
    @(negedge clk); lsu_mem_valid_in = 1'b0; #1;
    checks++;
    if (lsu_wen_out !== 1'b0 || lsu_hold_flag_out !== 1'b0) begin
      failures++;
      $display("[TB] FAIL sb_no_wb: wen %b hold %b expected 0 0", lsu_wen_out, lsu_hold_flag_out);
    end
    @(negedge clk); issue(1'b1, 3'b001, 32'h100, 32'h2, 32'hCAFEBEEF, 5'd0);
    @(negedge clk); lsu_req_in = 1'b0; lsu_mem_valid_in = 1'b1; #1;
    checks++;
    if (lsu_mem_byte_en_out !== 4'b1100 || lsu_mem_wdata_out !== 32'hBEEFBEEF) begin
      failures++;
      $display("[TB] FAIL sh_bus: be %b wdata %h expected 1100 beefbeef", lsu_mem_byte_en_out, lsu_mem_wdata_out);
    end
    @(negedge clk); lsu_mem_valid_in = 1'b0;
  endtask

  task automatic test_misalign();
    @(negedge clk); issue(1'b0, 3'b010, 32'h100, 32'h2, 32'h0, 5'd8); #1;
    checks++;
    if (lsu_hold_flag_out !== 1'b0 || lsu_mem_req_out !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mis_c0: hold %b req %b expected 0 0", lsu_hold_flag_out, lsu_mem_req_out);
    end
    @(negedge clk); lsu_req_in = 1'b0; #1;
    checks++;
    if (lsu_misalign_out !== 1'b1 || lsu_timeout_out !== 1'b0 || lsu_mem_req_out !== 1'b0 || lsu_wen_out !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mis_pulse: mis %b to %b req %b wen %b expected 1 0 0 0",
               lsu_misalign_out, lsu_timeout_out, lsu_mem_req_out, lsu_wen_out);
    end
    @(negedge clk); #1;
    checks++;
    if (lsu_misalign_out !== 1'b0 || lsu_mem_req_out !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mis_end: mis %b req %b expected 0 0", lsu_misalign_out, lsu_mem_req_out);
    end
  endtask

  task automatic test_illegal();
    @(negedge clk); issue(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 5'd3); #1;
    checks++;
    if (lsu_hold_flag_out !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ld_rv32_hold: hold %b expected 0", lsu_hold_flag_out);
    end
    @(negedge clk); lsu_req_in = 1'b0; #1;
    checks++;
    if (lsu_mem_req_out !== 1'b0 || lsu_misalign_out !== 1'b0 || lsu_timeout_out !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ld_rv32_noop: req %b mis %b to %b expected 0 0 0", lsu_mem_req_out, lsu_misalign_out, lsu_timeout_out);
    end
  endtask

  task automatic test_rd_zero();
    @(negedge clk); issue(1'b0, 3'b010, 32'h200, 32'h4, 32'h0, 5'd0);
    @(negedge clk); lsu_req_in = 1'b0; lsu_mem_valid_in = 1'b1; lsu_mem_rdata_in = 32'h12345678; #1;
    checks++;
    if (lsu_mem_addr_out !== 32'h204 || lsu_mem_byte_en_out !== 4'hF) begin
      failures++;
      $display("[TB] FAIL rd0_bus: addr %h be %h expected 00000204 f", lsu_mem_addr_out, lsu_mem_byte_en_out);
    end
    @(negedge clk); lsu_mem_valid_in = 1'b0; #1;
    checks++;
    if (lsu_wen_out !== 1'b0 || lsu_write_data_out !== 32'h0) begin
      failures++;
      $display("[TB] FAIL rd0_wb: wen %b data %h expected 0 00000000", lsu_wen_out, lsu_write_data_out);
    end
  endtask

  task automatic test_timeout();
    @(negedge clk); issue(1'b0, 3'b010, 32'h200, 32'h0, 32'h0, 5'd3);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk); lsu_req_in = 1'b0; #1;
      checks++;
      if (lsu_mem_req_out !== 1'b1 || lsu_timeout_out !== 1'b0) begin
        failures++;
        $display("[TB] FAIL to_wait%0d: req %b to %b expected 1 0", i, lsu_mem_req_out, lsu_timeout_out);
      end
    end
    @(negedge clk); #1;
    checks++;
    if (lsu_timeout_out !== 1'b1 || lsu_misalign_out !== 1'b0 || lsu_mem_req_out !== 1'b0 || lsu_hold_flag_out !== 1'b0) begin
      failures++;
      $display("[TB] FAIL to_pulse: to %b mis %b req %b hold %b expected 1 0 0 0",
               lsu_timeout_out, lsu_misalign_out, lsu_mem_req_out, lsu_hold_flag_out);
    end
    @(negedge clk); #1;
    checks++;
    if (lsu_timeout_out !== 1'b0 || lsu_wen_out !== 1'b0) begin
      failures++;
      $display("[TB] FAIL to_end: to %b wen %b expected 0 0", lsu_timeout_out, lsu_wen_out);
    end
  endtask

  task automatic test_flush();
    @(negedge clk); issue(1'b0, 3'b010, 32'h200, 32'h0, 32'h0, 5'd4);
    @(negedge clk); lsu_req_in = 1'b0;
    @(negedge clk); lsu_flush_in = 1'b1; #1;
    checks++;
    if (lsu_mem_req_out !== 1'b1) begin
      failures++;
      $display("[TB] FAIL flush_access: req %b expected 1", lsu_mem_req_out);
    end
    @(negedge clk); lsu_flush_in = 1'b0; lsu_mem_valid_in = 1'b1; lsu_mem_rdata_in = 32'h11111111; #1;
    checks++;
    if (lsu_mem_req_out !== 1'b0 || lsu_hold_flag_out !== 1'b0 || lsu_wen_out !== 1'b0) begin
      failures++;
      $display("[TB] FAIL flush_idle: req %b hold %b wen %b expected 0 0 0", lsu_mem_req_out, lsu_hold_flag_out, lsu_wen_out);
    end
    @(negedge clk); lsu_mem_valid_in = 1'b0; issue(1'b0, 3'b010, 32'h200, 32'h0, 32'h0, 5'd4); #1;
    checks++;
    if (lsu_wen_out !== 1'b0 || lsu_hold_flag_out !== 1'b1) begin
      failures++;
      $display("[TB] FAIL flush_stale: wen %b hold %b expected 0 1", lsu_wen_out, lsu_hold_flag_out);
    end
    @(negedge clk); lsu_req_in = 1'b0; lsu_mem_valid_in = 1'b1; lsu_mem_rdata_in = 32'hDEADBEEF;
    @(negedge clk); lsu_mem_valid_in = 1'b0; #1;
    checks++;
    if (lsu_wen_out !== 1'b1 || lsu_write_data_out !== 32'hDEADBEEF || lsu_write_addr_out !== 5'd4) begin
      failures++;
      $display("[TB] FAIL flush_next_lw: wen %b data %h rd %0d expected 1 deadbeef 4", lsu_wen_out, lsu_write_data_out, lsu_write_addr_out);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); issue(1'b0, 3'b010, 32'h300, 32'h0, 32'h0, 5'd6);
    @(negedge clk); lsu_req_in = 1'b0; #1;
    checks++;
    if (lsu_mem_req_out !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rst_mid_pre: req %b expected 1", lsu_mem_req_out);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (lsu_mem_req_out !== 1'b0 || lsu_hold_flag_out !== 1'b0 || lsu_mem_addr_out !== 32'h0 || lsu_mem_byte_en_out !== 4'h0) begin
      failures++;
      $display("[TB] FAIL rst_mid_async: req %b hold %b addr %h be %h expected 0 0 0 0",
               lsu_mem_req_out, lsu_hold_flag_out, lsu_mem_addr_out, lsu_mem_byte_en_out);
    end
    @(negedge clk); lsu_mem_valid_in = 1'b1; rst_n = 1'b1;
    @(negedge clk); lsu_mem_valid_in = 1'b0; #1;
    checks++;
    if (lsu_wen_out !== 1'b0 || lsu_mem_req_out !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rst_mid_after: wen %b req %b expected 0 0", lsu_wen_out, lsu_mem_req_out);
    end
  endtask

  initial begin
    test_reset();
    test_lb();
    test_lhu_wait();
    test_store();
    test_misalign();
    test_illegal();
    test_rd_zero();
    test_timeout();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
